// File: rtl/hall_speed_meter_if.sv
// ---------------------------------------------------------------------------
// hall_speed_meter_if
// Groups the hall-sensor input and the per-window measurement results of
// hall_speed_meter into a single bundle.
//   hall_in        raw hall inputs {W,V,U}, asynchronous to clk
//   engine_rev     14-bit rev value of the last window (saturated)
//   vehicle_speed  9-bit speed value of the last window (saturated)
//   direction      1 = forward net motion in the last window
//   hall_error     invalid code or skipped step seen in the last window
//   data_valid     one-cycle pulse when the result fields update
// Modports: slave = meter side, master = sensor/consumer side.
// ---------------------------------------------------------------------------
interface hall_speed_meter_if;
  logic [2:0]  hall_in;
  logic [13:0] engine_rev;
  logic [8:0]  vehicle_speed;
  logic        direction;
  logic        hall_error;
  logic        data_valid;

  modport slave (
    input  hall_in,
    output engine_rev, vehicle_speed, direction, hall_error, data_valid
  );

  modport master (
    output hall_in,
    input  engine_rev, vehicle_speed, direction, hall_error, data_valid
  );
endinterface

// File: rtl/hall_speed_meter.sv
// ---------------------------------------------------------------------------
// hall_speed_meter
// Counts commutation steps of a BLDC motor from its three hall sensors over
// a fixed gate window of GATE_CYCLE clocks, then scales the step total into
// a rev value and a speed value. Results update once per window with a
// one-cycle data_valid pulse and hold until the next update.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   hall_speed_meter_if.slave (hall_in in; results out)
// ---------------------------------------------------------------------------
module hall_speed_meter #(
  parameter int GATE_CYCLE = 5_000_000,
  parameter int CNT_WIDTH  = 16,
  parameter int REV_MUL    = 50,
  parameter int REV_SHIFT  = 0,
  parameter int SPD_MUL    = 3,
  parameter int SPD_SHIFT  = 4
) (
  input logic             clk,
  input logic             rst,
  hall_speed_meter_if.slave bus
);

  localparam int GW     = (GATE_CYCLE > 1) ? $clog2(GATE_CYCLE) : 1;
  localparam int RW_RAW = CNT_WIDTH + $clog2(REV_MUL + 1);
  localparam int SW_RAW = CNT_WIDTH + $clog2(SPD_MUL + 1);
  // keep product registers wide enough to compare against the output limits
  localparam int RW     = (RW_RAW > 15) ? RW_RAW : 15;
  localparam int SW     = (SW_RAW > 10) ? SW_RAW : 10;
  localparam int STAGES = 2;

  localparam logic [RW-1:0] REV_MAX = RW'(16383);
  localparam logic [SW-1:0] SPD_MAX = SW'(511);

  // -------------------------------------------------------------------------
  // hall input synchronizer and one-cycle history
  // -------------------------------------------------------------------------
  logic [2:0] sync1, hall_s, hall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      hall_s <= '0;
      hall_q <= '0;
    end else begin
      sync1  <= bus.hall_in;
      hall_s <= sync1;
      hall_q <= hall_s;
    end
  end

  // forward rotation order: 001 -> 011 -> 010 -> 110 -> 100 -> 101 -> 001
  function automatic logic [2:0] fwd_succ(input logic [2:0] c);
    logic [2:0] n;
    n = 3'b000;
    case (c)
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b100;
      3'b100:  n = 3'b101;
      3'b101:  n = 3'b001;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  function automatic logic code_ok(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  // -------------------------------------------------------------------------
  // step classification
  // -------------------------------------------------------------------------
  logic chg, both_ok, fwd_step, bwd_step, err_step;

  always_comb begin
    chg      = (hall_s != hall_q);
    both_ok  = code_ok(hall_s) && code_ok(hall_q);
    fwd_step = chg && both_ok && (hall_s == fwd_succ(hall_q));
    bwd_step = chg && both_ok && (hall_q == fwd_succ(hall_s));
    // invalid code on either side or a two-position jump
    err_step = chg && !fwd_step && !bwd_step;
  end

  // -------------------------------------------------------------------------
  // gate window
  // -------------------------------------------------------------------------
  logic [GW-1:0] gate;
  logic          terminal;

  assign terminal = (gate == GW'(GATE_CYCLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           gate <= '0;
    else if (terminal) gate <= '0;
    else               gate <= gate + GW'(1);
  end

  // -------------------------------------------------------------------------
  // live step counters; the event seen on the terminal cycle opens the next
  // window instead of closing the current one
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] fwd_cnt, bwd_cnt;
  logic                 err_live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt  <= '0;
      bwd_cnt  <= '0;
      err_live <= 1'b0;
    end else if (terminal) begin
      fwd_cnt  <= CNT_WIDTH'(fwd_step);
      bwd_cnt  <= CNT_WIDTH'(bwd_step);
      err_live <= err_step;
    end else begin
      if (fwd_step && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + CNT_WIDTH'(1);
      if (bwd_step && (bwd_cnt != '1)) bwd_cnt <= bwd_cnt + CNT_WIDTH'(1);
      err_live <= err_live | err_step;
    end
  end

  // window total, saturated back to counter width
  logic [CNT_WIDTH:0]   sum;
  logic [CNT_WIDTH-1:0] total;

  always_comb begin
    sum   = {1'b0, fwd_cnt} + {1'b0, bwd_cnt};
    total = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  end

  // -------------------------------------------------------------------------
  // calc pipeline: stage 1 captures full-width products at the terminal edge,
  // stage 2 shifts, saturates and publishes
  // -------------------------------------------------------------------------
  logic [STAGES:1] vld_pipe;
  logic [RW-1:0]   prod_r;
  logic [SW-1:0]   prod_s;
  logic            dir_snap, err_snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      prod_r   <= '0;
      prod_s   <= '0;
      dir_snap <= 1'b0;
      err_snap <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], terminal};
      if (terminal) begin
        prod_r   <= RW'(total) * RW'(REV_MUL);
        prod_s   <= SW'(total) * SW'(SPD_MUL);
        dir_snap <= (fwd_cnt >= bwd_cnt);   // tie reports forward
        err_snap <= err_live;
      end
    end
  end

  logic [RW-1:0] rev_sh;
  logic [SW-1:0] spd_sh;
  logic [13:0]   rev_sat;
  logic [8:0]    spd_sat;

  always_comb begin
    rev_sh  = prod_r >> REV_SHIFT;
    spd_sh  = prod_s >> SPD_SHIFT;
    rev_sat = (rev_sh > REV_MAX) ? 14'h3FFF : rev_sh[13:0];
    spd_sat = (spd_sh > SPD_MAX) ? 9'h1FF   : spd_sh[8:0];
  end

  logic [13:0] rev_q;
  logic [8:0]  spd_q;
  logic        dir_q, err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_q <= '0;
      spd_q <= '0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else if (vld_pipe[1]) begin
      rev_q <= rev_sat;
      spd_q <= spd_sat;
      dir_q <= dir_snap;
      err_q <= err_snap;
    end
  end

  assign bus.engine_rev    = rev_q;
  assign bus.vehicle_speed = spd_q;
  assign bus.direction     = dir_q;
  assign bus.hall_error    = err_q;
  assign bus.data_valid    = vld_pipe[STAGES];

endmodule

// File: tb/tb_hall_speed_meter.sv
// ---------------------------------------------------------------------------
// tb_hall_speed_meter
// Two meters share one hall input: dut_a uses the default scaling, dut_b uses
// SPD_MUL=30 to reach speed saturation. A window-level model predicts every
// output on every cycle; literal checks pin the model at key windows.
// ---------------------------------------------------------------------------
module tb_hall_speed_meter;
  localparam int G = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] hall = 3'b001;

  always #5 clk = ~clk;

  hall_speed_meter_if bus_a ();
  hall_speed_meter_if bus_b ();
  assign bus_a.hall_in = hall;
  assign bus_b.hall_in = hall;

  hall_speed_meter #(.GATE_CYCLE(G)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  hall_speed_meter #(.GATE_CYCLE(G), .SPD_MUL(30)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // clock edges since reset release

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int pos_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // -------------------------------------------------------------------------
  // model: window-level step bookkeeping
  // -------------------------------------------------------------------------
  typedef struct {
    int due; int rev; int spa; int spb; int dir; int err;
  } exp_t;

  exp_t       pend[$];
  exp_t       cur_exp;
  int         exp_dv;
  logic [2:0] h1, h2, h3;   // hall_in sampled 1, 2, 3 edges ago
  int         m_fwd, m_bwd, m_err;
  int         ev, pc, pp, c, tot;
  exp_t       e;

  initial begin
    cur_exp = '{default: 0};
    exp_dv  = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        cyc = 0; h1 = 0; h2 = 0; h3 = 0;
        m_fwd = 0; m_bwd = 0; m_err = 0;
        pend.delete();
        cur_exp = '{default: 0};
        exp_dv  = 0;
      end else begin
        cyc++;
        c  = cyc - 1;           // cycle being closed by this edge
        // a hall change is visible to the counters two samples later
        ev = 0;
        if (h2 != h3) begin
          pc = pos_of(h2); pp = pos_of(h3);
          if (pc >= 0 && pp >= 0 && pc == (pp + 1) % 6)      ev = 1;
          else if (pc >= 0 && pp >= 0 && pp == (pc + 1) % 6) ev = 2;
          else                                               ev = 3;
        end
        if (c % G == G - 1) begin
          tot   = imin(m_fwd + m_bwd, 65535);
          e.due = c + 2;
          e.rev = imin(tot * 50, 16383);
          e.spa = imin((tot * 3) >> 4, 511);
          e.spb = imin((tot * 30) >> 4, 511);
          e.dir = (m_fwd >= m_bwd) ? 1 : 0;
          e.err = m_err;
          pend.push_back(e);
          m_fwd = (ev == 1) ? 1 : 0;
          m_bwd = (ev == 2) ? 1 : 0;
          m_err = (ev == 3) ? 1 : 0;
        end else begin
          if (ev == 1) m_fwd = imin(m_fwd + 1, 65535);
          if (ev == 2) m_bwd = imin(m_bwd + 1, 65535);
          if (ev == 3) m_err = 1;
        end
        h3 = h2; h2 = h1; h1 = hall;
        exp_dv = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          cur_exp = pend.pop_front();
          exp_dv  = 1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // per-cycle compare against the model
  // -------------------------------------------------------------------------
  initial forever begin
    @(posedge clk);
    #1;
    chk("dv_a",  int'(bus_a.data_valid),    exp_dv);
    chk("rev_a", int'(bus_a.engine_rev),    cur_exp.rev);
    chk("spd_a", int'(bus_a.vehicle_speed), cur_exp.spa);
    chk("dir_a", int'(bus_a.direction),     cur_exp.dir);
    chk("err_a", int'(bus_a.hall_error),    cur_exp.err);
    chk("dv_b",  int'(bus_b.data_valid),    exp_dv);
    chk("rev_b", int'(bus_b.engine_rev),    cur_exp.rev);
    chk("spd_b", int'(bus_b.vehicle_speed), cur_exp.spb);
  end

  // -------------------------------------------------------------------------
  // stimulus
  // -------------------------------------------------------------------------
  int p = 0;

  task automatic at(input int n);
    int guard;
    guard = 0;
    while (cyc < n) begin
      @(negedge clk);
      guard++;
      if (guard > n + 20) begin
        failures++;
        $display("FAIL timeout waiting for cycle %0d (at %0d)", n, cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic step(input int dir, input int gap);
    p    = (dir > 0) ? (p + 1) % 6 : (p + 5) % 6;
    hall = seq[p];
    repeat (gap) @(negedge clk);
  endtask

  task automatic lit(input int dv, input int rev, input int spa, input int spb,
                     input int dir, input int err);
    chk("lit_dv",  int'(bus_a.data_valid),    dv);
    chk("lit_rev", int'(bus_a.engine_rev),    rev);
    chk("lit_spa", int'(bus_a.vehicle_speed), spa);
    chk("lit_spb", int'(bus_b.vehicle_speed), spb);
    chk("lit_dir", int'(bus_a.direction),     dir);
    chk("lit_err", int'(bus_a.hall_error),    err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle windows; the power-up transition 000 -> 001 flags window 0 only
    at(1000); chk("lit_dv_early", int'(bus_a.data_valid), 0);
    at(1001); lit(1, 0, 0, 0, 1, 1);
    at(1002); chk("lit_dv_pulse", int'(bus_a.data_valid), 0);
    at(2001); lit(1, 0, 0, 0, 1, 0);

    // 12 forward steps
    at(2100); for (int i = 0; i < 12; i++) step(1, 50);
    at(3001); lit(1, 600, 2, 22, 1, 0);

    // 7 backward + 3 forward
    at(3100);
    for (int i = 0; i < 7; i++) step(-1, 50);
    for (int i = 0; i < 3; i++) step(1, 50);
    at(4001); lit(1, 500, 1, 18, 0, 0);

    // invalid code, then a two-position jump
    at(4100); hall = 3'b111;
    at(4150); hall = seq[p];
    at(4200); p = (p + 2) % 6; hall = seq[p];
    at(5001); lit(1, 0, 0, 0, 1, 1);

    // clean window after the error
    at(5100); step(1, 50); step(1, 50);
    at(6001); lit(1, 100, 0, 3, 1, 0);

    // 400 steps: rev saturates, and dut_b speed saturates
    at(6050); for (int i = 0; i < 400; i++) step(1, 2);
    at(7001); lit(1, 16383, 75, 511, 1, 0);

    // step classified on the terminal cycle lands in the following window
    at(7997); step(1, 1);
    at(8001); lit(1, 0, 0, 0, 1, 0);
    at(9001); lit(1, 50, 0, 1, 1, 0);

    // reset in mid-window clears outputs at once
    at(9200); for (int i = 0; i < 3; i++) step(1, 20);
    at(9500);
    rst = 1'b1;
    #1;
    lit(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    at(1000); chk("lit_dv_rst_early", int'(bus_a.data_valid), 0);
    at(1001); lit(1, 0, 0, 0, 1, 1);
    at(1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hall_speed_meter.md
Name: hall_speed_meter

Overview:
- Measures brushless-motor shaft speed from the three hall-sensor inputs over a fixed gate window.
- Produces the 14-bit rev value and 9-bit speed value consumed by the CAN vehicle-data sender (engine_rev, vehicle_speed).
- Also provides a direction flag and a per-window hall-error flag.
- Outputs are refreshed once per window and held stable between windows.

Parameters:
- GATE_CYCLE, 5_000_000, clk cycles per measurement window (100 ms at 50 MHz); must be ≥ 4.
- CNT_WIDTH, 16, width of the step counters; they saturate at all-ones.
- REV_MUL, 50, rev scale factor (12 steps/rev, 10 windows/s: rpm = steps*50).
- REV_SHIFT, 0, right shift applied after the rev multiply.
- SPD_MUL, 3, speed scale factor.
- SPD_SHIFT, 4, right shift applied after the speed multiply.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- hall_in  in  3  raw hall inputs {W,V,U}, asynchronous to clk
- engine_rev  out  14  rev of the last window, saturated
- vehicle_speed  out  9  speed of the last window, saturated
- direction  out  1  1 = forward net motion in the last window
- hall_error  out  1  invalid code or skipped step seen in the last window
- data_valid  out  1  one-cycle pulse when the outputs update

Behaviour:
- Reset (async assert, sync-released logic): engine_rev=0, vehicle_speed=0, direction=0, hall_error=0, data_valid=0. Synchronizers, prev-code register, gate counter and step counters all clear to 0.
- Input sync: 2-FF synchronizer on hall_in gives hall_s. hall_q is hall_s delayed one cycle.
- Valid codes: 001, 011, 010, 110, 100, 101. Codes 000 and 111 are invalid.
- Forward sequence: 001→011→010→110→100→101→001. Backward is the reverse.
- Step classification, in a cycle where hall_s ≠ hall_q:
  - both codes valid and hall_s is the forward successor of hall_q: fwd step.
  - both codes valid and hall_s is the backward successor of hall_q: bwd step.
  - otherwise (invalid code on either side, or a two-position jump): set err_live; no step counted.
- hall_q = 000 after reset, so the first transition out of reset counts only as err_live. This is intended; the first window may flag an error.
- Live counters: fwd_cnt and bwd_cnt increment on their step type and saturate at 2^CNT_WIDTH-1.
- Gate counter: counts 0..GATE_CYCLE-1 and wraps. The terminal cycle is gate==GATE_CYCLE-1.
- At the terminal cycle T:
  - Snapshot total = fwd_cnt+bwd_cnt, saturated to CNT_WIDTH.
  - Snapshot dir = (fwd_cnt ≥ bwd_cnt), and err = err_live.
  - Live counters and err_live reload with this cycle's classification: the step/error of cycle T belongs to the new window, so the counter loads 1 if a step occurred at T, else 0.
- Calc pipeline (fixed latency 2 cycles, no stall):
  - T+1: products P_r = total*REV_MUL and P_s = total*SPD_MUL, registered at full width (no truncation).
  - T+2: engine_rev = min(P_r>>REV_SHIFT, 16383); vehicle_speed = min(P_s>>SPD_SHIFT, 511); direction = dir; hall_error = err; data_valid = 1 for exactly one cycle.
- Outputs hold their values until the next T+2. The pipeline never overlaps because GATE_CYCLE ≥ 4.
- Zero steps in a window: engine_rev=0, vehicle_speed=0, direction=1 (tie → forward).
- Reset asserted mid-window or mid-pipeline: everything returns immediately to its reset value, no data_valid pulse, and the first window restarts at gate=0 after release.
- Latency hall_in→counted: 3 clk (2 sync + compare).

Test Plan:
- Reset, hold hall_in=001, GATE_CYCLE=1000 → data_valid pulses at cycles 999+2 and every 1000 thereafter; engine_rev=0, vehicle_speed=0, direction=1, hall_error=0 from the second window on.
- 12 forward steps per window, spaced 50 cycles → engine_rev=600, vehicle_speed=(12*3)>>4=2, direction=1, hall_error=0.
- 7 backward steps plus 3 forward steps → total 10, engine_rev=500, vehicle_speed=1, direction=0.
- Inject code 111 once, then a jump 001→010 in a window → hall_error=1 for that window only; neither event counted; the next clean window reports hall_error=0.
- Steps at a rate exceeding the range (e.g. 400 steps/window) → engine_rev saturates to 16383, vehicle_speed=(400*3)>>4=75. With SPD_MUL=30, vehicle_speed saturates to 511.
- Step landing exactly on the terminal cycle is counted in the next window. Asserting rst at gate=500 clears all outputs asynchronously, and the next data_valid occurs 1001 cycles after release.
